// File: rtl/shiftadd_mult_seq.sv
// Sequential radix-2 shift-add multiplier feeding the shift-add reducer with (x, m, m_bl).
// Optional build macro SHIFTADD_MULT_EARLY_EXIT_EN: leave MULT as soon as the multiplier is exhausted.
//
// state | meaning
// IDLE  | ready for operands, x_o holds the last product
// MULT  | one shift-add iteration per clock
// DONE  | result valid, outputs held until ready_i
module shiftadd_mult_seq #(
  parameter int DATA_LENGTH = 64,
  parameter int OP_WIDTH    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [OP_WIDTH-1:0]    a_i,
  input  logic [OP_WIDTH-1:0]    b_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_LENGTH-1:0] x_o,
  output logic [DATA_LENGTH-1:0] m_o,
  output logic [DATA_LENGTH-1:0] m_bl_o,
  output logic                   busy_o
);

  localparam int CNT_W = $clog2(OP_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_e;

  state_e                 state_q, state_d;
  logic [DATA_LENGTH-1:0] a_sh_q, a_sh_d;
  logic [DATA_LENGTH-1:0] acc_q, acc_d;
  logic [DATA_LENGTH-1:0] x_q, x_d;
  logic [DATA_LENGTH-1:0] m_q, m_d;
  logic [DATA_LENGTH-1:0] m_bl_q, m_bl_d;
  logic [OP_WIDTH-1:0]    b_sh_q, b_sh_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   last_iter;

  // Bit length = index of the highest set bit plus one; zero for an all-zero modulus.
  function automatic logic [DATA_LENGTH-1:0] bit_length(input logic [DATA_LENGTH-1:0] v);
    logic [DATA_LENGTH-1:0] len;
    len = '0;
    for (int i = 0; i < DATA_LENGTH; i++) begin
      if (v[i]) len = DATA_LENGTH'(i + 1);
    end
    return len;
  endfunction

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    acc_d     = acc_q;
    x_d       = x_q;
    m_d       = m_q;
    m_bl_d    = m_bl_q;
    cnt_d     = cnt_q;
    last_iter = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_sh_d  = DATA_LENGTH'(a_i);
          b_sh_d  = b_i;
          m_d     = m_i;
          m_bl_d  = bit_length(m_i);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MULT;
        end
      end
      MULT: begin
        if (b_sh_q[0]) acc_d = acc_q + a_sh_q;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
`ifdef SHIFTADD_MULT_EARLY_EXIT_EN
        last_iter = (b_sh_d == '0) || (cnt_q == CNT_W'(OP_WIDTH - 1));
`else
        last_iter = (cnt_q == CNT_W'(OP_WIDTH - 1));
`endif
        if (last_iter) begin
          x_d     = acc_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      m_q     <= '0;
      m_bl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      m_q     <= m_d;
      m_bl_q  <= m_bl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign busy_o  = (state_q != IDLE);
  assign x_o     = x_q;
  assign m_o     = m_q;
  assign m_bl_o  = m_bl_q;

endmodule
